// File: rtl/pkg_testbench_defs.sv
// Shared definitions for the ALU monitor: opcode encodings, the pending-entry
// layout, default sizes and the reference model of the ALU under observation.
package pkg_testbench_defs;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;
  // Widest operand the reference model supports; the monitor's DATA_W must not exceed it.
  localparam int MAX_W      = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_MUL = 3'd5,
    ALU_SHL = 3'd6,
    ALU_SHR = 3'd7
  } alu_op_t;

  // One pending request at the default operand width.
  typedef struct packed {
    alu_op_t               op;
    logic [DATA_W_DEF-1:0] a;
    logic [DATA_W_DEF-1:0] b;
  } mon_entry_t;

  // Reference result in 2*w bits. Operands arrive zero-extended to MAX_W, the
  // arithmetic is done in 2*MAX_W bits and the result is masked down to 2*w,
  // which gives the modulo-2^(2w) behaviour required for SUB.
  function automatic logic [2*MAX_W-1:0] alu_ref(input alu_op_t op,
                                                 input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input int unsigned w);
    logic [2*MAX_W-1:0] ax;
    logic [2*MAX_W-1:0] bx;
    logic [2*MAX_W-1:0] r;
    logic [2*MAX_W-1:0] mask;
    ax = {{MAX_W{1'b0}}, a};
    bx = {{MAX_W{1'b0}}, b};
    case (op)
      ALU_ADD: r = ax + bx;
      ALU_SUB: r = ax - bx;
      ALU_AND: r = ax & bx;
      ALU_OR:  r = ax | bx;
      ALU_XOR: r = ax ^ bx;
      ALU_MUL: r = ax * bx;
      ALU_SHL: r = ax << b[2:0];
      ALU_SHR: r = ax >> b[2:0];
      default: r = '0;
    endcase
    if (w >= MAX_W) mask = '1;
    else            mask = ({{(2*MAX_W-1){1'b0}}, 1'b1} << (2*w)) - 1'b1;
    return r & mask;
  endfunction

endpackage

// File: rtl/alu_mon_fifo.sv
// In-order pending-request FIFO. Pointers wrap modulo DEPTH; a count one bit
// wider than the pointers separates full from empty. A pop is honoured only
// when an entry existed at the start of the cycle, so a push into an empty
// FIFO is never bypassed to the read side.
module alu_mon_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_rdata,
  output logic         o_empty,
  output logic         o_full,
  output logic         o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_pop;
  logic w_push;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == (AW+1)'(DEPTH));
  assign w_pop      = i_pop & ~o_empty;
  // A full FIFO still takes a push when the same cycle frees a slot.
  assign w_push     = i_push & (~o_full | w_pop);
  assign o_overflow = i_push & o_full & ~w_pop;
  assign o_rdata    = r_mem[r_rd_ptr];

  // Storage array: data only, no reset needed.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_monitor.sv
// Passive scoreboard for a request/response ALU: queues accepted requests,
// pairs each response with the oldest pending request, compares against the
// reference model and reports the checked transaction one cycle later.
module alu_monitor
  import pkg_testbench_defs::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  input  logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [DATA_W-1:0]   req_a,
  input  logic [DATA_W-1:0]   req_b,
  input  logic                rsp_valid,
  input  logic [2*DATA_W-1:0] rsp_result,
  output logic                mon_valid,
  output logic [2:0]          mon_op,
  output logic [DATA_W-1:0]   mon_a,
  output logic [DATA_W-1:0]   mon_b,
  output logic [2*DATA_W-1:0] mon_result,
  output logic [2*DATA_W-1:0] mon_expected,
  output logic                mon_match,
  output logic [15:0]         pass_count,
  output logic [15:0]         fail_count,
  output logic                err_overflow,
  output logic                err_unexpected
);

  localparam int EW = 3 + 2*DATA_W;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic                w_push;
  logic                w_pop;
  logic                w_unexp;
  logic                w_empty;
  logic                w_full;
  logic                w_overflow;
  logic [EW-1:0]       w_rdata;
  logic [2:0]          w_head_op;
  logic [DATA_W-1:0]   w_head_a;
  logic [DATA_W-1:0]   w_head_b;
  logic [2*DATA_W-1:0] w_expected;
  logic                w_match;

  logic                r_mon_valid;
  logic [2:0]          r_mon_op;
  logic [DATA_W-1:0]   r_mon_a;
  logic [DATA_W-1:0]   r_mon_b;
  logic [2*DATA_W-1:0] r_mon_result;
  logic [2*DATA_W-1:0] r_mon_expected;
  logic                r_mon_match;
  logic [15:0]         r_pass_count;
  logic [15:0]         r_fail_count;
  logic                r_err_overflow;
  logic                r_err_unexpected;

  assign w_push  = req_valid & req_ready;
  // Emptiness is judged at the start of the cycle, so a same-cycle push cannot satisfy a response.
  assign w_pop   = rsp_valid & ~w_empty;
  assign w_unexp = rsp_valid & w_empty;

  alu_mon_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .i_push     (w_push),
    .i_pop      (rsp_valid),
    .i_wdata    ({req_op, req_a, req_b}),
    .o_rdata    (w_rdata),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .o_overflow (w_overflow)
  );

  assign w_head_op  = w_rdata[EW-1 -: 3];
  assign w_head_a   = w_rdata[2*DATA_W-1 -: DATA_W];
  assign w_head_b   = w_rdata[DATA_W-1:0];
  assign w_expected = (2*DATA_W)'(alu_ref(alu_op_t'(w_head_op), MAX_W'(w_head_a),
                                          MAX_W'(w_head_b), DATA_W));
  assign w_match    = (rsp_result == w_expected);

  // Capture the checked transaction, tally the verdict and latch sticky errors.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mon_valid      <= 1'b0;
      r_mon_op         <= '0;
      r_mon_a          <= '0;
      r_mon_b          <= '0;
      r_mon_result     <= '0;
      r_mon_expected   <= '0;
      r_mon_match      <= 1'b0;
      r_pass_count     <= '0;
      r_fail_count     <= '0;
      r_err_overflow   <= 1'b0;
      r_err_unexpected <= 1'b0;
    end else begin
      r_mon_valid <= w_pop;
      if (w_pop) begin
        r_mon_op       <= w_head_op;
        r_mon_a        <= w_head_a;
        r_mon_b        <= w_head_b;
        r_mon_result   <= rsp_result;
        r_mon_expected <= w_expected;
        r_mon_match    <= w_match;
        if (w_match) r_pass_count <= sat_inc(r_pass_count);
        else         r_fail_count <= sat_inc(r_fail_count);
      end
      if (w_overflow) r_err_overflow   <= 1'b1;
      if (w_unexp)    r_err_unexpected <= 1'b1;
    end
  end

  assign mon_valid      = r_mon_valid;
  assign mon_op         = r_mon_op;
  assign mon_a          = r_mon_a;
  assign mon_b          = r_mon_b;
  assign mon_result     = r_mon_result;
  assign mon_expected   = r_mon_expected;
  assign mon_match      = r_mon_match;
  assign pass_count     = r_pass_count;
  assign fail_count     = r_fail_count;
  assign err_overflow   = r_err_overflow;
  assign err_unexpected = r_err_unexpected;

  // The full flag is only consumed inside the FIFO's overflow logic.
  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_alu_monitor.sv
// Directed bench for alu_monitor: table of single request/response pairs plus
// hand-written multi-cycle sequences (ordering, overflow, empty response, reset).
module tb_alu_monitor;
  import pkg_testbench_defs::*;

  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, req_ready;
  logic [2:0]    req_op;
  logic [DW-1:0] req_a, req_b;
  logic          rsp_valid;
  logic [2*DW-1:0] rsp_result;
  logic          mon_valid;
  logic [2:0]    mon_op;
  logic [DW-1:0] mon_a, mon_b;
  logic [2*DW-1:0] mon_result, mon_expected;
  logic          mon_match;
  logic [15:0]   pass_count, fail_count;
  logic          err_overflow, err_unexpected;

  alu_monitor #(.DATA_W(DW), .DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .mon_valid(mon_valid), .mon_op(mon_op), .mon_a(mon_a), .mon_b(mon_b),
    .mon_result(mon_result), .mon_expected(mon_expected), .mon_match(mon_match),
    .pass_count(pass_count), .fail_count(fail_count),
    .err_overflow(err_overflow), .err_unexpected(err_unexpected)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic [15:0] exp;
    logic        match;
  } vec_t;

  vec_t vecs [10];
  int n_pass  = 0;
  int n_total = 0;
  int exp_pass = 0;
  int exp_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_valid = 1'b1; req_ready = 1'b1; req_op = op; req_a = a; req_b = b;
    tick();
    req_valid = 1'b0; req_ready = 1'b0;
  endtask

  task automatic resp(input logic [15:0] res);
    rsp_valid = 1'b1; rsp_result = res;
    tick();
    rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_pass = 0;
    exp_fail = 0;
  endtask

  task automatic chk_mon(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] res,
                         input logic [15:0] exp, input logic match);
    if (match) exp_pass++; else exp_fail++;
    chk({tag, "_valid"},  32'(mon_valid),    32'd1);
    chk({tag, "_op"},     32'(mon_op),       32'(op));
    chk({tag, "_a"},      32'(mon_a),        32'(a));
    chk({tag, "_b"},      32'(mon_b),        32'(b));
    chk({tag, "_result"}, 32'(mon_result),   32'(res));
    chk({tag, "_exp"},    32'(mon_expected), 32'(exp));
    chk({tag, "_match"},  32'(mon_match),    32'(match));
    chk({tag, "_pass"},   32'(pass_count),   32'(exp_pass));
    chk({tag, "_fail"},   32'(fail_count),   32'(exp_fail));
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_ready = 1'b0; req_op = '0;
    req_a = '0; req_b = '0; rsp_valid = 1'b0; rsp_result = '0;
    vecs[0] = '{3'd0, 8'hFF, 8'h01, 16'h0100, 16'h0100, 1'b1};
    vecs[1] = '{3'd1, 8'h01, 8'h02, 16'h00FF, 16'hFFFF, 1'b0};
    vecs[2] = '{3'd2, 8'hF0, 8'h3C, 16'h0030, 16'h0030, 1'b1};
    vecs[3] = '{3'd3, 8'hF0, 8'h0F, 16'h00FF, 16'h00FF, 1'b1};
    vecs[4] = '{3'd4, 8'hAA, 8'h55, 16'h00FF, 16'h00FF, 1'b1};
    vecs[5] = '{3'd5, 8'hFF, 8'hFF, 16'hFE01, 16'hFE01, 1'b1};
    vecs[6] = '{3'd6, 8'h81, 8'h0B, 16'h0408, 16'h0408, 1'b1};
    vecs[7] = '{3'd7, 8'h80, 8'h0F, 16'h0001, 16'h0001, 1'b1};
    vecs[8] = '{3'd1, 8'h05, 8'h03, 16'h0002, 16'h0002, 1'b1};
    vecs[9] = '{3'd0, 8'hFF, 8'hFF, 16'h0000, 16'h01FE, 1'b0};

    tick(); tick();
    reset = 1'b0;
    chk("rst_valid",  32'(mon_valid),      32'd0);
    chk("rst_exp",    32'(mon_expected),   32'd0);
    chk("rst_pass",   32'(pass_count),     32'd0);
    chk("rst_fail",   32'(fail_count),     32'd0);
    chk("rst_ovf",    32'(err_overflow),   32'd0);
    chk("rst_unexp",  32'(err_unexpected), 32'd0);

    // Single request/response pairs, one per table entry.
    for (int i = 0; i < 10; i++) begin
      push(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_prevalid", i), 32'(mon_valid), 32'd0);
      resp(vecs[i].res);
      chk_mon($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
              vecs[i].res, vecs[i].exp, vecs[i].match);
      tick();
      chk($sformatf("v%0d_pulse", i), 32'(mon_valid), 32'd0);
      chk($sformatf("v%0d_hold", i), 32'(mon_expected), 32'(vecs[i].exp));
    end

    // Back-to-back requests, back-to-back in-order responses.
    push(3'd5, 8'h0F, 8'h11);
    push(3'd6, 8'h81, 8'h03);
    push(3'd4, 8'hAA, 8'h55);
    rsp_valid = 1'b1; rsp_result = 16'h00FF; tick();
    chk_mon("s3a", 3'd5, 8'h0F, 8'h11, 16'h00FF, 16'h00FF, 1'b1);
    rsp_result = 16'h0408; tick();
    chk_mon("s3b", 3'd6, 8'h81, 8'h03, 16'h0408, 16'h0408, 1'b1);
    rsp_result = 16'h00FF; tick();
    chk_mon("s3c", 3'd4, 8'hAA, 8'h55, 16'h00FF, 16'h00FF, 1'b1);
    rsp_valid = 1'b0; tick();
    chk("s3_pulse", 32'(mon_valid), 32'd0);

    // Offered but not accepted request, then a response on the empty FIFO.
    req_valid = 1'b1; req_ready = 1'b0; req_op = 3'd0; req_a = 8'h33; req_b = 8'h44;
    tick();
    req_valid = 1'b0;
    chk("s5_pre_unexp", 32'(err_unexpected), 32'd0);
    resp(16'h0077);
    chk("s5_unexp", 32'(err_unexpected), 32'd1);
    chk("s5_valid", 32'(mon_valid),      32'd0);
    chk("s5_pass",  32'(pass_count),     32'(exp_pass));
    chk("s5_fail",  32'(fail_count),     32'(exp_fail));

    // Request accepted in the same cycle as a response on the empty FIFO: no bypass.
    req_valid = 1'b1; req_ready = 1'b1; req_op = 3'd3; req_a = 8'h0C; req_b = 8'h30;
    rsp_valid = 1'b1; rsp_result = 16'h003C;
    tick();
    req_valid = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
    chk("nb_valid", 32'(mon_valid), 32'd0);
    resp(16'h003C);
    chk_mon("nb", 3'd3, 8'h0C, 8'h30, 16'h003C, 16'h003C, 1'b1);

    // Overflow: five requests into a four-deep FIFO.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) chk("s4_ovf_before", 32'(err_overflow), 32'd0);
      push(3'd0, 8'(i), 8'h10);
    end
    chk("s4_ovf", 32'(err_overflow), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      resp(16'(i + 16));
      chk_mon($sformatf("s4_%0d", i), 3'd0, 8'(i), 8'h10, 16'(i + 16), 16'(i + 16), 1'b1);
    end
    resp(16'h0015);
    chk("s4_extra_valid", 32'(mon_valid),      32'd0);
    chk("s4_extra_unexp", 32'(err_unexpected), 32'd1);

    // Push and pop together while full: both happen, no overflow.
    do_reset();
    for (int i = 1; i <= 4; i++) push(3'd0, 8'(i), 8'h20);
    req_valid = 1'b1; req_ready = 1'b1; req_op = 3'd0; req_a = 8'h05; req_b = 8'h20;
    rsp_valid = 1'b1; rsp_result = 16'h0021;
    tick();
    req_valid = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
    chk("pp_ovf", 32'(err_overflow), 32'd0);
    chk_mon("pp_1", 3'd0, 8'h01, 8'h20, 16'h0021, 16'h0021, 1'b1);
    for (int i = 2; i <= 5; i++) begin
      resp(16'(i + 32));
      chk_mon($sformatf("pp_%0d", i), 3'd0, 8'(i), 8'h20, 16'(i + 32), 16'(i + 32), 1'b1);
    end
    chk("pp_unexp", 32'(err_unexpected), 32'd0);

    // Reset with requests pending discards them.
    push(3'd0, 8'h01, 8'h01);
    push(3'd0, 8'h02, 8'h02);
    resp(16'h0002);
    do_reset();
    chk("s6_valid", 32'(mon_valid),      32'd0);
    chk("s6_a",     32'(mon_a),          32'd0);
    chk("s6_res",   32'(mon_result),     32'd0);
    chk("s6_exp",   32'(mon_expected),   32'd0);
    chk("s6_pass",  32'(pass_count),     32'd0);
    chk("s6_fail",  32'(fail_count),     32'd0);
    chk("s6_ovf",   32'(err_overflow),   32'd0);
    chk("s6_unexp0", 32'(err_unexpected), 32'd0);
    resp(16'h0004);
    chk("s6_unexp", 32'(err_unexpected), 32'd1);
    chk("s6_nomon", 32'(mon_valid),      32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
